// File: rtl/rs_ldst_oq_if.sv
// Dispatch / issue / wakeup / branch-resolve bundle for the in-order LDST reservation station.
// slave = reservation station side, master = dispatch/exec/testbench side.
interface rs_ldst_oq_if #(
  parameter int ENT_SEL     = 3,
  parameter int DATA_LEN    = 32,
  parameter int ADDR_LEN    = 32,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5,
  parameter int WB_NUM      = 5
);
  logic                       we1, we2;
  logic [ADDR_LEN-1:0]        wpc_1, wpc_2;
  logic [DATA_LEN-1:0]        wsrc1_1, wsrc2_1, wsrc1_2, wsrc2_2;
  logic                       wvalid1_1, wvalid2_1, wvalid1_2, wvalid2_2;
  logic [DATA_LEN-1:0]        wimm_1, wimm_2;
  logic [RRF_SEL-1:0]         wrrftag_1, wrrftag_2;
  logic                       wdstval_1, wdstval_2;
  logic [SPECTAG_LEN-1:0]     wspectag_1, wspectag_2;
  logic                       wspecbit_1, wspecbit_2;
  logic [ENT_SEL:0]           free_cnt;
  logic                       alloc_err;
  logic                       issue_valid, issue_ack;
  logic [DATA_LEN-1:0]        ex_src1, ex_src2, ex_imm;
  logic [ADDR_LEN-1:0]        ex_pc;
  logic [RRF_SEL-1:0]         ex_rrftag;
  logic                       ex_dstval, ex_specbit;
  logic [SPECTAG_LEN-1:0]     ex_spectag;
  logic [WB_NUM-1:0]          wb_valid;
  logic [WB_NUM*RRF_SEL-1:0]  wb_tag;
  logic [WB_NUM*DATA_LEN-1:0] wb_data;
  logic                       prmiss, prsuccess;
  logic [SPECTAG_LEN-1:0]     prtag, specfixtag;

  modport slave (
    input  we1, we2, wpc_1, wpc_2, wsrc1_1, wsrc2_1, wsrc1_2, wsrc2_2,
           wvalid1_1, wvalid2_1, wvalid1_2, wvalid2_2, wimm_1, wimm_2,
           wrrftag_1, wrrftag_2, wdstval_1, wdstval_2, wspectag_1, wspectag_2,
           wspecbit_1, wspecbit_2, issue_ack, wb_valid, wb_tag, wb_data,
           prmiss, prsuccess, prtag, specfixtag,
    output free_cnt, alloc_err, issue_valid, ex_src1, ex_src2, ex_imm, ex_pc,
           ex_rrftag, ex_dstval, ex_specbit, ex_spectag
  );
  modport master (
    output we1, we2, wpc_1, wpc_2, wsrc1_1, wsrc2_1, wsrc1_2, wsrc2_2,
           wvalid1_1, wvalid2_1, wvalid1_2, wvalid2_2, wimm_1, wimm_2,
           wrrftag_1, wrrftag_2, wdstval_1, wdstval_2, wspectag_1, wspectag_2,
           wspecbit_1, wspecbit_2, issue_ack, wb_valid, wb_tag, wb_data,
           prmiss, prsuccess, prtag, specfixtag,
    input  free_cnt, alloc_err, issue_valid, ex_src1, ex_src2, ex_imm, ex_pc,
           ex_rrftag, ex_dstval, ex_specbit, ex_spectag
  );
endinterface

// File: rtl/rs_ldst_oq.sv
// Age-ordered LDST reservation station: circular queue, head-only issue, wakeup capture, branch flush.
// Option: define RS_LDST_OQ_BYPASS_EN for same-cycle wakeup->issue forwarding on the head entry.
module rs_ldst_oq #(
  parameter int ENT_NUM     = 8,
  parameter int ENT_SEL     = 3,
  parameter int DATA_LEN    = 32,
  parameter int ADDR_LEN    = 32,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5,
  parameter int WB_NUM      = 5
) (
  input logic        clk,
  input logic        reset,
  rs_ldst_oq_if.slave io
);
  typedef logic [ENT_SEL-1:0] ptr_t;
  typedef logic [ENT_SEL:0]   cnt_t;

  logic [ENT_NUM-1:0]                  busy, valid1, valid2, specbit, dstval;
  logic [ENT_NUM-1:0][DATA_LEN-1:0]    src1, src2, imm;
  logic [ENT_NUM-1:0][ADDR_LEN-1:0]    pc;
  logic [ENT_NUM-1:0][RRF_SEL-1:0]     rrftag;
  logic [ENT_NUM-1:0][SPECTAG_LEN-1:0] spectag;
  logic [ENT_NUM-1:0][DATA_LEN:0]      wk1, wk2;
  logic [ENT_NUM-1:0]                  survive;
  logic [DATA_LEN:0]                   ws11, ws21, ws12, ws22;
  ptr_t head, tail, tail_p1;
  cnt_t free_q, n, n_surv;
  logic alloc_err_q, drop, alloc_ok, alloc_err_d, rdy1, rdy2, issue_valid, fire;

  // Unresolved sources hold their rename tag in the low bits; lowest bus index wins.
  function automatic logic [DATA_LEN:0] snoop(input logic [RRF_SEL-1:0] tag,
                                              input logic [WB_NUM-1:0] vld,
                                              input logic [WB_NUM*RRF_SEL-1:0] tags,
                                              input logic [WB_NUM*DATA_LEN-1:0] data);
    logic [DATA_LEN:0] r;
    r = '0;
    for (int i = WB_NUM-1; i >= 0; i--)
      if (vld[i] && tags[i*RRF_SEL +: RRF_SEL] == tag) r = {1'b1, data[i*DATA_LEN +: DATA_LEN]};
    return r;
  endfunction

  for (genvar e = 0; e < ENT_NUM; e++) begin : g_ent
    assign wk1[e]     = snoop(src1[e][RRF_SEL-1:0], io.wb_valid, io.wb_tag, io.wb_data);
    assign wk2[e]     = snoop(src2[e][RRF_SEL-1:0], io.wb_valid, io.wb_tag, io.wb_data);
    assign survive[e] = busy[e] & |(spectag[e] & io.specfixtag);
  end

  assign ws11 = snoop(io.wsrc1_1[RRF_SEL-1:0], io.wb_valid, io.wb_tag, io.wb_data);
  assign ws21 = snoop(io.wsrc2_1[RRF_SEL-1:0], io.wb_valid, io.wb_tag, io.wb_data);
  assign ws12 = snoop(io.wsrc1_2[RRF_SEL-1:0], io.wb_valid, io.wb_tag, io.wb_data);
  assign ws22 = snoop(io.wsrc2_2[RRF_SEL-1:0], io.wb_valid, io.wb_tag, io.wb_data);

  always_comb begin
    n           = cnt_t'(io.we1) + cnt_t'(io.we2);
    drop        = (io.we2 & ~io.we1) | (n > free_q);
    alloc_ok    = io.we1 & ~drop & ~io.prmiss;
    alloc_err_d = (io.we1 | io.we2) & drop & ~io.prmiss;
    n_surv      = '0;
    for (int e = 0; e < ENT_NUM; e++) n_surv = n_surv + cnt_t'(survive[e]);
  end

  assign tail_p1 = tail + ptr_t'(1);

`ifdef RS_LDST_OQ_BYPASS_EN
  assign rdy1       = valid1[head] | wk1[head][DATA_LEN];
  assign rdy2       = valid2[head] | wk2[head][DATA_LEN];
  assign io.ex_src1 = (valid1[head] | ~wk1[head][DATA_LEN]) ? src1[head] : wk1[head][DATA_LEN-1:0];
  assign io.ex_src2 = (valid2[head] | ~wk2[head][DATA_LEN]) ? src2[head] : wk2[head][DATA_LEN-1:0];
`else
  assign rdy1       = valid1[head];
  assign rdy2       = valid2[head];
  assign io.ex_src1 = src1[head];
  assign io.ex_src2 = src2[head];
`endif

  assign issue_valid    = busy[head] & rdy1 & rdy2 & ~io.prmiss;
  assign fire           = issue_valid & io.issue_ack;
  assign io.issue_valid = issue_valid;
  assign io.free_cnt    = free_q;
  assign io.alloc_err   = alloc_err_q;
  assign io.ex_pc       = pc[head];
  assign io.ex_imm      = imm[head];
  assign io.ex_rrftag   = rrftag[head];
  assign io.ex_dstval   = dstval[head];
  assign io.ex_spectag  = spectag[head];
  // Show the head's specbit as already cleared when its branch resolves this cycle.
  assign io.ex_specbit  = specbit[head] & ~(io.prsuccess & (spectag[head] == io.prtag));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;  tail <= '0;  free_q <= cnt_t'(ENT_NUM);  alloc_err_q <= 1'b0;
      busy <= '0;  valid1 <= '0;  valid2 <= '0;  specbit <= '0;  dstval <= '0;
      src1 <= '0;  src2 <= '0;  imm <= '0;  pc <= '0;  rrftag <= '0;  spectag <= '0;
    end else begin
      alloc_err_q <= alloc_err_d;
      for (int e = 0; e < ENT_NUM; e++) begin
        if (busy[e] && !valid1[e] && wk1[e][DATA_LEN]) begin
          valid1[e] <= 1'b1;  src1[e] <= wk1[e][DATA_LEN-1:0];
        end
        if (busy[e] && !valid2[e] && wk2[e][DATA_LEN]) begin
          valid2[e] <= 1'b1;  src2[e] <= wk2[e][DATA_LEN-1:0];
        end
        if (io.prsuccess && spectag[e] == io.prtag) specbit[e] <= 1'b0;
      end
      if (io.prmiss) begin
        // Killed entries form the youngest suffix, so survivors stay contiguous from head.
        busy    <= busy & survive;
        specbit <= '0;
        tail    <= head + ptr_t'(n_surv);
        free_q  <= cnt_t'(ENT_NUM) - n_surv;
      end else begin
        if (fire) begin
          busy[head] <= 1'b0;
          head       <= head + ptr_t'(1);
        end
        if (alloc_ok) begin
          busy[tail]    <= 1'b1;
          pc[tail]      <= io.wpc_1;
          imm[tail]     <= io.wimm_1;
          rrftag[tail]  <= io.wrrftag_1;
          dstval[tail]  <= io.wdstval_1;
          spectag[tail] <= io.wspectag_1;
          specbit[tail] <= io.wspecbit_1 & ~(io.prsuccess && io.wspectag_1 == io.prtag);
          valid1[tail]  <= io.wvalid1_1 | ws11[DATA_LEN];
          valid2[tail]  <= io.wvalid2_1 | ws21[DATA_LEN];
          src1[tail]    <= (io.wvalid1_1 | ~ws11[DATA_LEN]) ? io.wsrc1_1 : ws11[DATA_LEN-1:0];
          src2[tail]    <= (io.wvalid2_1 | ~ws21[DATA_LEN]) ? io.wsrc2_1 : ws21[DATA_LEN-1:0];
          if (io.we2) begin
            busy[tail_p1]    <= 1'b1;
            pc[tail_p1]      <= io.wpc_2;
            imm[tail_p1]     <= io.wimm_2;
            rrftag[tail_p1]  <= io.wrrftag_2;
            dstval[tail_p1]  <= io.wdstval_2;
            spectag[tail_p1] <= io.wspectag_2;
            specbit[tail_p1] <= io.wspecbit_2 & ~(io.prsuccess && io.wspectag_2 == io.prtag);
            valid1[tail_p1]  <= io.wvalid1_2 | ws12[DATA_LEN];
            valid2[tail_p1]  <= io.wvalid2_2 | ws22[DATA_LEN];
            src1[tail_p1]    <= (io.wvalid1_2 | ~ws12[DATA_LEN]) ? io.wsrc1_2 : ws12[DATA_LEN-1:0];
            src2[tail_p1]    <= (io.wvalid2_2 | ~ws22[DATA_LEN]) ? io.wsrc2_2 : ws22[DATA_LEN-1:0];
          end
          tail <= tail + ptr_t'(n);
        end
        free_q <= free_q - (alloc_ok ? n : cnt_t'(0)) + cnt_t'(fire);
      end
    end
  end
endmodule

// File: tb/tb_rs_ldst_oq.sv
// Scoreboard bench for rs_ldst_oq: expected issues queued at dispatch, checked in order at issue.
module tb_rs_ldst_oq;
`ifdef RS_LDST_OQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rs_ldst_oq_if io();
  rs_ldst_oq dut (.clk(clk), .reset(reset), .io(io));

  typedef struct { logic [31:0] pc, s1, s2; logic sb; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;

  // Scoreboard: every accepted issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && io.issue_valid === 1'b1 && io.issue_ack === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_issue pc got=%h want=none", io.ex_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if ({io.ex_pc, io.ex_src1, io.ex_src2, io.ex_specbit, io.ex_imm} !==
            {mon_e.pc, mon_e.s1, mon_e.s2, mon_e.sb, mon_e.pc + 32'h10}) begin
          bad++;
          $display("FAIL sb_issue got pc=%h s1=%h s2=%h sb=%b imm=%h want pc=%h s1=%h s2=%h sb=%b imm=%h",
                   io.ex_pc, io.ex_src1, io.ex_src2, io.ex_specbit, io.ex_imm,
                   mon_e.pc, mon_e.s1, mon_e.s2, mon_e.sb, mon_e.pc + 32'h10);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    io.we1 = 1'b0; io.we2 = 1'b0; io.wb_valid = '0; io.prmiss = 1'b0; io.prsuccess = 1'b0;
  endtask

  task automatic init_in();
    idle();
    io.wpc_1 = '0; io.wpc_2 = '0; io.wsrc1_1 = '0; io.wsrc2_1 = '0; io.wsrc1_2 = '0; io.wsrc2_2 = '0;
    io.wvalid1_1 = 0; io.wvalid2_1 = 0; io.wvalid1_2 = 0; io.wvalid2_2 = 0;
    io.wimm_1 = '0; io.wimm_2 = '0; io.wrrftag_1 = '0; io.wrrftag_2 = '0;
    io.wdstval_1 = 0; io.wdstval_2 = 0; io.wspectag_1 = '0; io.wspectag_2 = '0;
    io.wspecbit_1 = 0; io.wspecbit_2 = 0; io.issue_ack = 0;
    io.wb_tag = '0; io.wb_data = '0; io.prtag = '0; io.specfixtag = '0;
  endtask

  task automatic slot1(input logic [31:0] pc, input logic [31:0] s1, input logic v1,
                       input logic [31:0] s2, input logic v2, input logic [4:0] st, input logic sb);
    io.we1 = 1'b1; io.wpc_1 = pc; io.wsrc1_1 = s1; io.wvalid1_1 = v1; io.wsrc2_1 = s2; io.wvalid2_1 = v2;
    io.wimm_1 = pc + 32'h10; io.wrrftag_1 = pc[5:0]; io.wdstval_1 = 1'b1; io.wspectag_1 = st; io.wspecbit_1 = sb;
  endtask

  task automatic slot2(input logic [31:0] pc, input logic [31:0] s1, input logic v1,
                       input logic [31:0] s2, input logic v2, input logic [4:0] st, input logic sb);
    io.we2 = 1'b1; io.wpc_2 = pc; io.wsrc1_2 = s1; io.wvalid1_2 = v1; io.wsrc2_2 = s2; io.wvalid2_2 = v2;
    io.wimm_2 = pc + 32'h10; io.wrrftag_2 = pc[5:0]; io.wdstval_2 = 1'b1; io.wspectag_2 = st; io.wspecbit_2 = sb;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2, input logic sb);
    exp_t e;
    e.pc = pc; e.s1 = s1; e.s2 = s2; e.sb = sb;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; init_in(); #2; reset = 1'b0; #3;
    total++; if (io.free_cnt !== 4'd8) begin bad++; $display("FAIL rst_free got=%0d want=8", io.free_cnt); end
    total++; if (io.issue_valid !== 1'b0) begin bad++; $display("FAIL rst_iv got=%b want=0", io.issue_valid); end
    total++; if (io.alloc_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", io.alloc_err); end
    total++; if (io.ex_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", io.ex_pc); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_in_order();
    tick();
    slot1(32'h100, 32'h1, 1, 32'h2, 1, 5'd1, 0); push(32'h100, 32'h1, 32'h2, 0);
    slot2(32'h104, 32'h3, 1, 32'h4, 1, 5'd1, 0); push(32'h104, 32'h3, 32'h4, 0);
    io.issue_ack = 1'b1;
    tick(); idle();
    @(negedge clk);
    total++; if (io.free_cnt !== 4'd6) begin bad++; $display("FAIL t2_free_alloc got=%0d want=6", io.free_cnt); end
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t2_drain left=%0d want=0", exp_q.size()); end
    @(negedge clk);
    total++; if (io.free_cnt !== 4'd8) begin bad++; $display("FAIL t2_free_end got=%0d want=8", io.free_cnt); end
    total++; if (io.issue_valid !== 1'b0) begin bad++; $display("FAIL t2_empty_iv got=%b want=0", io.issue_valid); end
    io.issue_ack = 1'b0;
  endtask

  task automatic test_wakeup();
    tick();
    io.issue_ack = 1'b1;
    slot1(32'h200, 32'd7, 0, 32'h55, 1, 5'd1, 0); push(32'h200, 32'hDEAD, 32'h55, 0);
    tick(); idle();
    io.wb_valid = 5'b10100;
    io.wb_tag[2*6 +: 6] = 6'd7; io.wb_data[2*32 +: 32] = 32'hDEAD;
    io.wb_tag[4*6 +: 6] = 6'd7; io.wb_data[4*32 +: 32] = 32'hBEEF;
    @(negedge clk);
    total++; if (io.issue_valid !== BYP) begin bad++; $display("FAIL t3_wake_cycle_iv got=%b want=%b", io.issue_valid, BYP); end
    tick(); io.wb_valid = '0;
    @(negedge clk);
    total++; if (io.issue_valid !== ~BYP) begin bad++; $display("FAIL t3_next_cycle_iv got=%b want=%b", io.issue_valid, ~BYP); end
    tick();
    slot1(32'h204, 32'h11, 1, 32'd9, 0, 5'd1, 0); push(32'h204, 32'h11, 32'h1234, 0);
    io.wb_valid = 5'b00001; io.wb_tag[5:0] = 6'd9; io.wb_data[31:0] = 32'h1234;
    tick(); idle();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t3_drain left=%0d want=0", exp_q.size()); end
    @(negedge clk);
    total++; if (io.free_cnt !== 4'd8) begin bad++; $display("FAIL t3_free_end got=%0d want=8", io.free_cnt); end
    io.issue_ack = 1'b0;
  endtask

  task automatic test_full_wrap();
    tick();
    for (int k = 0; k < 4; k++) begin
      slot1(32'h400 + 32'(16*k), 32'(k), 1, 32'h40, 1, 5'd1, 0); push(32'h400 + 32'(16*k), 32'(k), 32'h40, 0);
      slot2(32'h404 + 32'(16*k), 32'(k+8), 1, 32'h41, 1, 5'd1, 0); push(32'h404 + 32'(16*k), 32'(k+8), 32'h41, 0);
      tick();
    end
    idle();
    slot1(32'h4F0, 32'h0, 1, 32'h0, 1, 5'd1, 0);
    tick(); idle();
    @(negedge clk);
    total++; if (io.alloc_err !== 1'b1) begin bad++; $display("FAIL t4_overflow_err got=%b want=1", io.alloc_err); end
    total++; if (io.free_cnt !== 4'd0) begin bad++; $display("FAIL t4_full_free got=%0d want=0", io.free_cnt); end
    tick();
    @(negedge clk);
    total++; if (io.alloc_err !== 1'b0) begin bad++; $display("FAIL t4_err_pulse got=%b want=0", io.alloc_err); end
    io.issue_ack = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    for (int k = 0; k < 4; k++) begin
      slot1(32'h480 + 32'(4*k), 32'h5, 1, 32'h6, 1, 5'd1, 0); push(32'h480 + 32'(4*k), 32'h5, 32'h6, 0);
      tick();
    end
    idle();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t4_drain left=%0d want=0", exp_q.size()); end
    @(negedge clk);
    total++; if (io.free_cnt !== 4'd8) begin bad++; $display("FAIL t4_free_end got=%0d want=8", io.free_cnt); end
    tick();
    slot2(32'h4F4, 32'h0, 1, 32'h0, 1, 5'd1, 0);
    tick(); idle();
    @(negedge clk);
    total++; if (io.alloc_err !== 1'b1) begin bad++; $display("FAIL t4_we2_only_err got=%b want=1", io.alloc_err); end
    total++; if (io.free_cnt !== 4'd8) begin bad++; $display("FAIL t4_we2_only_free got=%0d want=8", io.free_cnt); end
    io.issue_ack = 1'b0;
  endtask

  task automatic test_prmiss();
    tick();
    slot1(32'h300, 32'h1, 1, 32'h2, 1, 5'd1, 1); push(32'h300, 32'h1, 32'h2, 0);
    slot2(32'h304, 32'h3, 1, 32'h4, 1, 5'd1, 1); push(32'h304, 32'h3, 32'h4, 0);
    tick();
    slot1(32'h308, 32'h5, 1, 32'h6, 1, 5'd2, 1); push(32'h308, 32'h5, 32'h6, 1);
    slot2(32'h30C, 32'h7, 1, 32'h8, 1, 5'd2, 1); push(32'h30C, 32'h7, 32'h8, 1);
    tick(); idle();
    io.prmiss = 1'b1; io.specfixtag = 5'b00001; io.issue_ack = 1'b1;
    slot1(32'h3F0, 32'h0, 1, 32'h0, 1, 5'd1, 0);
    @(negedge clk);
    total++; if (io.issue_valid !== 1'b0) begin bad++; $display("FAIL t5_miss_iv got=%b want=0", io.issue_valid); end
    void'(exp_q.pop_back()); void'(exp_q.pop_back());
    tick(); idle();
    @(negedge clk);
    total++; if (io.alloc_err !== 1'b0) begin bad++; $display("FAIL t5_miss_err got=%b want=0", io.alloc_err); end
    total++; if (io.free_cnt !== 4'd6) begin bad++; $display("FAIL t5_survivors_free got=%0d want=6", io.free_cnt); end
    tick();
    slot1(32'h500, 32'h9, 1, 32'hA, 1, 5'd1, 0); push(32'h500, 32'h9, 32'hA, 0);
    tick(); idle();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t5_drain left=%0d want=0", exp_q.size()); end
    @(negedge clk);
    total++; if (io.free_cnt !== 4'd8) begin bad++; $display("FAIL t5_free_end got=%0d want=8", io.free_cnt); end
    io.issue_ack = 1'b0; io.specfixtag = '0;
  endtask

  task automatic test_prsuccess();
    tick();
    slot1(32'h600, 32'h1, 1, 32'h2, 1, 5'd2, 1); push(32'h600, 32'h1, 32'h2, 0);
    slot2(32'h604, 32'h3, 1, 32'h4, 1, 5'd1, 1); push(32'h604, 32'h3, 32'h4, 1);
    tick(); idle();
    io.prsuccess = 1'b1; io.prtag = 5'b00010;
    slot1(32'h608, 32'h5, 1, 32'h6, 1, 5'd2, 1); push(32'h608, 32'h5, 32'h6, 0);
    @(negedge clk);
    total++; if (io.ex_specbit !== 1'b0) begin bad++; $display("FAIL t6_head_specbit got=%b want=0", io.ex_specbit); end
    tick(); idle(); io.prtag = '0; io.issue_ack = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t6_drain left=%0d want=0", exp_q.size()); end
    @(negedge clk);
    total++; if (io.free_cnt !== 4'd8) begin bad++; $display("FAIL t6_free_end got=%0d want=8", io.free_cnt); end
    io.issue_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick();
    slot1(32'h700, 32'h1, 1, 32'h2, 1, 5'd1, 1);
    slot2(32'h704, 32'h3, 1, 32'h4, 1, 5'd1, 1);
    tick(); idle();
    @(negedge clk);
    total++; if (io.issue_valid !== 1'b1) begin bad++; $display("FAIL t1_pre_iv got=%b want=1", io.issue_valid); end
    #2 reset = 1'b0; #1;
    total++; if (io.free_cnt !== 4'd8) begin bad++; $display("FAIL t1_free got=%0d want=8", io.free_cnt); end
    total++; if (io.issue_valid !== 1'b0) begin bad++; $display("FAIL t1_iv got=%b want=0", io.issue_valid); end
    total++; if ({io.ex_pc, io.ex_src1, io.ex_specbit} !== 65'h0) begin
      bad++; $display("FAIL t1_outputs got pc=%h s1=%h sb=%b want 0", io.ex_pc, io.ex_src1, io.ex_specbit);
    end
    exp_q.delete();
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_wakeup();
    test_full_wrap();
    test_prmiss();
    test_prsuccess();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
